multi_signal_capture: RTL and testbench

MULTI_SIGNAL_CAPTURE -- requirements
Module: multi_signal_capture

---
 rtl/multi_signal_capture_pkg.sv | 9 +
 rtl/capture_channel.sv | 58 +++++
 rtl/multi_signal_capture.sv | 99 +++++++++
 tb/tb_multi_signal_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_signal_capture_pkg.sv
// Shared constants for the multi-signal capture block.
//   MODE_LEVEL : every sampled cycle with get high is a hit
//   MODE_EDGE  : only a low-to-high transition of get is a hit
package multi_signal_capture_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/capture_channel.sv
// One capture channel: history flop for edge detection, sticky captured flag
// and saturating hit counter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : window start; clears flag and counter (a same-cycle hit wins)
//   get, en    : capture request and channel enable
//   mode       : MODE_LEVEL / MODE_EDGE
//   hit        : combinational hit for this cycle (feeds first-hit logic)
//   q, cnt     : registered captured flag and hit count
module capture_channel
  import multi_signal_capture_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             get,
  input  logic             en,
  input  logic             mode,
  output logic             hit,
  output logic             q,
  output logic [CNT_W-1:0] cnt
);

  // get history is tracked every cycle so a mode switch sees the true last value
  logic get_q;

  always_comb begin
    hit = 1'b0;
    if (mode == MODE_EDGE) begin
      hit = en & get & ~get_q;
    end else begin
      hit = en & get;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      get_q <= 1'b0;
      q     <= 1'b0;
      cnt   <= '0;
    end else begin
      get_q <= get;
      if (hit) begin
        q <= 1'b1;
      end else if (clr) begin
        q <= 1'b0;
      end
      if (clr) begin
        cnt <= hit ? CNT_W'(1) : '0;
      end else if (hit && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_signal_capture.sv
// Multi-channel capture with sticky flags, saturating hit counters, a window
// timestamp that advances every other cycle, and first-hit recording.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   live_rising  : window start; clears all capture state and the timestamp
//   get, en      : per-channel request / enable
//   mode         : 0 level capture, 1 rising-edge capture
//   q, any_q     : sticky captured flags and their OR
//   hit_cnt      : per-channel counters, channel i at [i*CNT_W +: CNT_W]
//   first_valid, first_ch, first_ts : first hit of the window
module multi_signal_capture
  import multi_signal_capture_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TS_W  = 16,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  live_rising,
  input  logic [N_CH-1:0]       get,
  input  logic [N_CH-1:0]       en,
  input  logic                  mode,
  output logic [N_CH-1:0]       q,
  output logic                  any_q,
  output logic [N_CH*CNT_W-1:0] hit_cnt,
  output logic                  first_valid,
  output logic [CH_W-1:0]       first_ch,
  output logic [TS_W-1:0]       first_ts
);

  logic [N_CH-1:0] hit;
  logic [CH_W-1:0] first_idx;
  logic [TS_W-1:0] ts_q;
  logic            phase_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    capture_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (live_rising),
      .get  (get[i]),
      .en   (en[i]),
      .mode (mode),
      .hit  (hit[i]),
      .q    (q[i]),
      .cnt  (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign any_q = |q;

  // Lowest-index hitting channel; scanning downward lets the lowest win.
  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        first_idx = CH_W'(i);
      end
    end
  end

  // phase_q halves the rate: ts advances on the second cycle of each pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      phase_q <= 1'b0;
    end else if (live_rising) begin
      ts_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      if (phase_q && (ts_q != '1)) begin
        ts_q <= ts_q + TS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_valid <= 1'b0;
      first_ch    <= '0;
      first_ts    <= '0;
    end else if (live_rising) begin
      // A hit coincident with the window start becomes that window's first hit.
      first_valid <= |hit;
      first_ch    <= first_idx;
      first_ts    <= '0;
    end else if (!first_valid && (|hit)) begin
      first_valid <= 1'b1;
      first_ch    <= first_idx;
      first_ts    <= ts_q;
    end
  end

endmodule

// File: tb/tb_multi_signal_capture.sv
module tb_multi_signal_capture;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        live_rising = 1'b0;
  logic [7:0]  get = '0;
  logic [7:0]  en = '0;
  logic        mode = 1'b0;

  logic [7:0]  q, q4;
  logic        any_q, any4;
  logic [63:0] hc;
  logic [31:0] hc4;
  logic        fv, fv4;
  logic [2:0]  fc, fc4;
  logic [15:0] fts, fts4;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] q_m;
  logic [7:0] prev_m;
  int         cnt_m[N];
  int         cnt4_m[N];
  logic       fv_m;
  int         fc_m;
  int         fts_m;
  int         win_k;  // edges since window start

  multi_signal_capture dut (
    .clk(clk), .rst_n(rst_n), .live_rising(live_rising), .get(get), .en(en), .mode(mode),
    .q(q), .any_q(any_q), .hit_cnt(hc), .first_valid(fv), .first_ch(fc), .first_ts(fts)
  );

  multi_signal_capture #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .live_rising(live_rising), .get(get), .en(en), .mode(mode),
    .q(q4), .any_q(any4), .hit_cnt(hc4), .first_valid(fv4), .first_ch(fc4), .first_ts(fts4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_m    = '0;
    prev_m = '0;
    fv_m   = 1'b0;
    fc_m   = 0;
    fts_m  = 0;
    win_k  = 0;
    for (int i = 0; i < N; i++) begin
      cnt_m[i]  = 0;
      cnt4_m[i] = 0;
    end
  endtask

  // Applies the rules to the inputs sampled at this edge.
  task automatic model_edge();
    logic [7:0] h;
    int ts_pre;
    int low;
    ts_pre = win_k / 2;
    if (ts_pre > 65535) ts_pre = 65535;
    for (int i = 0; i < N; i++) begin
      if (mode) h[i] = en[i] && get[i] && !prev_m[i];
      else      h[i] = en[i] && get[i];
    end
    if (live_rising) begin
      q_m   = '0;
      fv_m  = 1'b0;
      fc_m  = 0;
      fts_m = 0;
      for (int i = 0; i < N; i++) begin
        cnt_m[i]  = 0;
        cnt4_m[i] = 0;
      end
    end
    low = -1;
    for (int i = 0; i < N; i++) begin
      if (h[i]) begin
        q_m[i] = 1'b1;
        if (cnt_m[i] < 255) cnt_m[i]++;
        if (cnt4_m[i] < 15) cnt4_m[i]++;
        if (low < 0) low = i;
      end
    end
    if (low >= 0 && !fv_m) begin
      fv_m  = 1'b1;
      fc_m  = low;
      fts_m = live_rising ? 0 : ts_pre;
    end
    win_k  = live_rising ? 0 : win_k + 1;
    prev_m = get;
  endtask

  task automatic check_all();
    logic [63:0] e8;
    logic [31:0] e4;
    for (int i = 0; i < N; i++) begin
      e8[i*8 +: 8] = 8'(cnt_m[i]);
      e4[i*4 +: 4] = 4'(cnt4_m[i]);
    end
    chk("q",        64'(q),     64'(q_m));
    chk("any_q",    64'(any_q), 64'(q_m != 0));
    chk("hit_cnt",  hc,         e8);
    chk("first_valid", 64'(fv), 64'(fv_m));
    chk("first_ch", 64'(fc),    64'(fc_m));
    chk("first_ts", 64'(fts),   64'(fts_m));
    chk("q_w4",     64'(q4),    64'(q_m));
    chk("any_q_w4", 64'(any4),  64'(q_m != 0));
    chk("hit_cnt_w4", 64'(hc4), 64'(e4));
    chk("first_valid_w4", 64'(fv4), 64'(fv_m));
    chk("first_ch_w4", 64'(fc4), 64'(fc_m));
    chk("first_ts_w4", 64'(fts4), 64'(fts_m));
  endtask

  task automatic step(input logic lv, input logic [7:0] g, input logic [7:0] e, input logic m);
    live_rising = lv;
    get         = g;
    en          = e;
    mode        = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases on negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       r_mode;
    logic [7:0] r_en;
    logic [7:0] r_get;
    logic       r_live;

    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Level capture on channel 3 for five cycles
    step(1'b1, 8'h00, 8'hFF, 1'b0);
    repeat (5) step(1'b0, 8'h08, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 8'hFF, 1'b0);
    chk("lvl_q", 64'(q), 64'h08);
    chk("lvl_cnt3", 64'(hc[31:24]), 64'd5);
    chk("lvl_first_ch", 64'(fc), 64'd3);
    chk("lvl_first_valid", 64'(fv), 64'd1);

    // Edge capture: high 5, low 1, high 2 -> two hits
    step(1'b1, 8'h00, 8'hFF, 1'b1);
    repeat (5) step(1'b0, 8'h01, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 8'hFF, 1'b1);
    repeat (2) step(1'b0, 8'h01, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 8'hFF, 1'b1);
    chk("edge_cnt0", 64'(hc[7:0]), 64'd2);
    chk("edge_q0", 64'(q[0]), 64'd1);

    // Saturation of the 4-bit counter
    step(1'b1, 8'h00, 8'hFF, 1'b0);
    repeat (20) step(1'b0, 8'h02, 8'hFF, 1'b0);
    chk("sat_cnt1_w4", 64'(hc4[7:4]), 64'd15);
    chk("cnt1_w8", 64'(hc[15:8]), 64'd20);

    // First-hit priority and timestamp: hit lands on the 15th edge after window start
    step(1'b1, 8'h00, 8'hFF, 1'b0);
    repeat (14) step(1'b0, 8'h00, 8'hFF, 1'b0);
    step(1'b0, 8'h24, 8'hFF, 1'b0);
    chk("prio_first_ch", 64'(fc), 64'd2);
    chk("prio_first_ts", 64'(fts), 64'd7);
    step(1'b0, 8'h01, 8'hFF, 1'b0);
    chk("prio_first_ch_held", 64'(fc), 64'd2);

    // Window start coinciding with a hit
    step(1'b0, 8'hFF, 8'hFF, 1'b0);
    chk("all_q", 64'(q), 64'hFF);
    step(1'b1, 8'h10, 8'hFF, 1'b0);
    chk("live_hit_q", 64'(q), 64'h10);
    chk("live_hit_cnt4", 64'(hc[39:32]), 64'd1);
    chk("live_hit_first_ts", 64'(fts), 64'd0);
    chk("live_hit_first_ch", 64'(fc), 64'd4);

    // Mid-window reset with restricted enables
    step(1'b1, 8'h0F, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 8'hF0, 1'b0);
    do_reset();
    chk("rst_q", 64'(q), 64'h00);
    step(1'b0, 8'h01, 8'hF0, 1'b0);
    chk("rst_no_capture", 64'(q), 64'h00);

    // get held high across reset release in edge mode hits on the first edge
    step(1'b0, 8'h01, 8'hFF, 1'b1);
    do_reset();
    step(1'b0, 8'h01, 8'hFF, 1'b1);
    chk("rst_edge_hit", 64'(q[0]), 64'd1);

    // Randomized traffic
    r_mode = 1'b0;
    r_en   = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0) r_mode = ~r_mode;
      if ($urandom_range(15) == 0) r_en = 8'($urandom);
      if ($urandom_range(1) == 0) r_get = 8'($urandom) & 8'($urandom);
      else r_get = 8'($urandom);
      r_live = ($urandom_range(24) == 0);
      step(r_live, r_get, r_en, r_mode);
      if ($urandom_range(150) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
